bioee_clkdiv_multi: RTL and testbench

Multi-channel programmable clock divider and clock-enable generator for the acquisition board fabric. It is the parametrised successor of the single-channel even-only divider. Each channel divides clkin by any runtime integer D ≥ 2 (odd or even), produces a registered divided clock plus a one-cycle tick strobe, updates its divisor glitch-free at period boundaries, and all channels can be phase-aligned with a single pulse. It feeds ADC/DAC sample clocks and the enables of slower fabric logic.

---
 rtl/bioee_clkdiv_multi_pkg.sv | 21 ++
 rtl/bioee_clkdiv_chan.sv | 96 +++++++++
 rtl/bioee_clkdiv_multi.sv | 36 +++
 tb/tb_bioee_clkdiv_multi.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/bioee_clkdiv_multi_pkg.sv
// Shared constants and types for the multi-channel clock divider.
// Divisor encodings 0 and 1 carry special meaning: parked and full-rate enable.
package bioee_clkdiv_multi_pkg;

    localparam int NCH_DEF   = 4;
    localparam int DIV_W_DEF = 16;

    localparam int D_PARK   = 0;
    localparam int D_ENABLE = 1;

    typedef enum logic {
        CH_IDLE = 1'b0,
        CH_RUN  = 1'b1
    } chan_state_e;

    // Cycles spent high in one period of divisor d: ceil(d/2).
    function automatic int high_cycles(input int d);
        return d - (d / 2);
    endfunction

endpackage

// File: rtl/bioee_clkdiv_chan.sv
// One divider channel: period counter, shadow divisor loaded only at period
// boundaries, and registered clkout/tick/running outputs.
module bioee_clkdiv_chan
    import bioee_clkdiv_multi_pkg::*;
#(
    parameter int DIV_W = DIV_W_DEF
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_enable,
    input  logic [DIV_W-1:0] i_divider,
    input  logic             i_align,
    output logic             o_clkout,
    output logic             o_tick,
    output logic             o_running
);

    localparam logic [DIV_W-1:0] L_PARK   = DIV_W'(D_PARK);
    localparam logic [DIV_W-1:0] L_ENABLE = DIV_W'(D_ENABLE);
    localparam logic [DIV_W-1:0] L_ONE    = DIV_W'(1);

    chan_state_e      r_state;
    logic [DIV_W-1:0] r_cnt;
    logic [DIV_W-1:0] r_dact;
    logic             r_clkout;
    logic             r_tick;

    chan_state_e      w_state_next;
    logic [DIV_W-1:0] w_cnt_next;
    logic [DIV_W-1:0] w_dact_next;
    logic             w_clkout_next;
    logic             w_tick_next;

    logic [DIV_W-1:0] w_cnt_inc;
    logic [DIV_W-1:0] w_high;
    logic             w_wrap;
    logic             w_load;

    assign w_cnt_inc = r_cnt + L_ONE;
    assign w_high    = r_dact - (r_dact >> 1);
    assign w_wrap    = (r_cnt == (r_dact - L_ONE));

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state  <= CH_IDLE;
            r_cnt    <= '0;
            r_dact   <= '0;
            r_clkout <= 1'b0;
            r_tick   <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_cnt    <= w_cnt_next;
            r_dact   <= w_dact_next;
            r_clkout <= w_clkout_next;
            r_tick   <= w_tick_next;
        end
    end

    // A start, an align and a natural wrap all share the same load path, so a
    // coincident align and wrap can only ever produce one tick.
    always_comb begin
        w_state_next  = r_state;
        w_cnt_next    = r_cnt;
        w_dact_next   = r_dact;
        w_clkout_next = 1'b0;
        w_tick_next   = 1'b0;
        w_load        = 1'b0;

        if (!i_enable) begin
            w_state_next = CH_IDLE;
            w_cnt_next   = '0;
        end else if ((r_state == CH_IDLE) || i_align || w_wrap) begin
            w_load = 1'b1;
        end else begin
            w_cnt_next    = w_cnt_inc;
            w_clkout_next = (w_cnt_inc < w_high);
        end

        if (w_load) begin
            w_cnt_next  = '0;
            w_dact_next = i_divider;
            if (i_divider == L_PARK) begin
                w_state_next = CH_IDLE;
            end else begin
                w_state_next  = CH_RUN;
                w_tick_next   = 1'b1;
                w_clkout_next = (i_divider != L_ENABLE);
            end
        end
    end

    assign o_clkout  = r_clkout;
    assign o_tick    = r_tick;
    assign o_running = (r_state == CH_RUN);

endmodule

// File: rtl/bioee_clkdiv_multi.sv
// Multi-channel programmable clock divider / clock-enable generator.
// Each channel divides clkin by its own runtime divisor; align restarts all in phase.
module bioee_clkdiv_multi
    import bioee_clkdiv_multi_pkg::*;
#(
    parameter int NCH   = NCH_DEF,
    parameter int DIV_W = DIV_W_DEF
) (
    input  logic                 clkin,
    input  logic                 reset,
    input  logic [NCH-1:0]       enable,
    input  logic [NCH*DIV_W-1:0] divider,
    input  logic                 align,
    output logic [NCH-1:0]       clkout,
    output logic [NCH-1:0]       tick,
    output logic [NCH-1:0]       running
);

    generate
        for (genvar gi = 0; gi < NCH; gi++) begin : g_chan
            bioee_clkdiv_chan #(
                .DIV_W (DIV_W)
            ) u_chan (
                .i_clk     (clkin),
                .i_reset   (reset),
                .i_enable  (enable[gi]),
                .i_divider (divider[gi*DIV_W +: DIV_W]),
                .i_align   (align),
                .o_clkout  (clkout[gi]),
                .o_tick    (tick[gi]),
                .o_running (running[gi])
            );
        end
    endgenerate

endmodule

// File: tb/tb_bioee_clkdiv_multi.sv
// Directed self-checking bench for bioee_clkdiv_multi (NCH=4, DIV_W=16).
module tb_bioee_clkdiv_multi;

    localparam int NCH   = 4;
    localparam int DIV_W = 16;

    logic                 clkin;
    logic                 reset;
    logic [NCH-1:0]       enable;
    logic [NCH*DIV_W-1:0] divider;
    logic                 align;
    logic [NCH-1:0]       clkout;
    logic [NCH-1:0]       tick;
    logic [NCH-1:0]       running;

    int n_checks;
    int n_pass;
    int n_fail;

    bioee_clkdiv_multi #(
        .NCH   (NCH),
        .DIV_W (DIV_W)
    ) dut (
        .clkin   (clkin),
        .reset   (reset),
        .enable  (enable),
        .divider (divider),
        .align   (align),
        .clkout  (clkout),
        .tick    (tick),
        .running (running)
    );

    initial clkin = 1'b0;
    always #5 clkin = ~clkin;

    task automatic step();
        @(posedge clkin);
        #1;
    endtask

    task automatic set_div(input int ch, input int d);
        divider[ch*DIV_W +: DIV_W] = DIV_W'(d);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        assert (obs === exp_v) begin
            n_pass++;
            $display("check %s: observed %0h expected %0h ok", tag, obs, exp_v);
        end else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    initial begin
        logic [3:0] e_clk;
        logic [3:0] e_tick;
        n_checks = 0;
        n_pass   = 0;
        n_fail   = 0;
        align    = 1'b0;
        enable   = 4'hF;
        for (int c = 0; c < NCH; c++) set_div(c, 4);

        // Reset held for three cycles with every channel enabled.
        reset = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            check($sformatf("rst_clkout_%0d", k), 32'(clkout), 32'h0);
            check($sformatf("rst_tick_%0d", k), 32'(tick), 32'h0);
            check($sformatf("rst_running_%0d", k), 32'(running), 32'h0);
        end
        reset = 1'b0;

        // D=4 on all channels: clkout 1100, tick every 4th cycle.
        for (int k = 0; k < 8; k++) begin
            step();
            e_clk  = ((k % 4) < 2) ? 4'hF : 4'h0;
            e_tick = ((k % 4) == 0) ? 4'hF : 4'h0;
            check($sformatf("d4_clkout_%0d", k), 32'(clkout), 32'(e_clk));
            check($sformatf("d4_tick_%0d", k), 32'(tick), 32'(e_tick));
        end
        check("d4_running", 32'(running), 32'hF);

        // Disable everything: stop is immediate.
        enable = 4'h0;
        step();
        check("stop_clkout", 32'(clkout), 32'h0);
        check("stop_running", 32'(running), 32'h0);

        // Channel 0, D=5: 11100.
        set_div(0, 5);
        enable = 4'b0001;
        for (int k = 0; k < 10; k++) begin
            step();
            check($sformatf("d5_clk_%0d", k), 32'(clkout[0]), 32'(((k % 5) < 3) ? 1 : 0));
            check($sformatf("d5_tick_%0d", k), 32'(tick[0]), 32'(((k % 5) == 0) ? 1 : 0));
        end
        check("d5_running", 32'(running[0]), 32'h1);

        // Channel 1, D=6 then D=10 written at cnt=2: old period completes first.
        enable = 4'h0;
        step();
        set_div(1, 6);
        enable = 4'b0010;
        for (int k = 0; k < 17; k++) begin
            step();
            if (k < 6) begin
                check($sformatf("dchg_clk_%0d", k), 32'(clkout[1]), 32'((k < 3) ? 1 : 0));
                check($sformatf("dchg_tick_%0d", k), 32'(tick[1]), 32'((k == 0) ? 1 : 0));
            end else begin
                check($sformatf("dchg_clk_%0d", k), 32'(clkout[1]), 32'((((k - 6) % 10) < 5) ? 1 : 0));
                check($sformatf("dchg_tick_%0d", k), 32'(tick[1]), 32'((((k - 6) % 10) == 0) ? 1 : 0));
            end
            if (k == 2) set_div(1, 10);
        end

        // Align: ch0 D=3 and ch1 D=7 started on different cycles.
        enable = 4'h0;
        step();
        set_div(0, 3);
        set_div(1, 7);
        enable = 4'b0001;
        step();
        step();
        enable = 4'b0011;
        step();
        step();
        step();
        align = 1'b1;
        step();
        align = 1'b0;
        for (int k = 0; k < 14; k++) begin
            e_clk  = {2'b00, (((k % 7) < 4) ? 1'b1 : 1'b0), (((k % 3) < 2) ? 1'b1 : 1'b0)};
            e_tick = {2'b00, (((k % 7) == 0) ? 1'b1 : 1'b0), (((k % 3) == 0) ? 1'b1 : 1'b0)};
            check($sformatf("align_clk_%0d", k), 32'(clkout), 32'(e_clk));
            check($sformatf("align_tick_%0d", k), 32'(tick), 32'(e_tick));
            step();
        end

        // Channel 2: D=1 full-rate enable, then park on D=0, then D=8.
        enable = 4'h0;
        step();
        set_div(2, 1);
        enable = 4'b0100;
        for (int k = 0; k < 4; k++) begin
            step();
            check($sformatf("d1_tick_%0d", k), 32'(tick[2]), 32'h1);
            check($sformatf("d1_clk_%0d", k), 32'(clkout[2]), 32'h0);
            check($sformatf("d1_running_%0d", k), 32'(running[2]), 32'h1);
        end
        set_div(2, 0);
        enable = 4'h0;
        step();
        enable = 4'b0100;
        for (int k = 0; k < 2; k++) begin
            step();
            check($sformatf("park_out_%0d", k), 32'({tick[2], clkout[2], running[2]}), 32'h0);
        end
        set_div(2, 8);
        for (int k = 0; k < 9; k++) begin
            step();
            check($sformatf("d8_clk_%0d", k), 32'(clkout[2]), 32'(((k % 8) < 4) ? 1 : 0));
            check($sformatf("d8_tick_%0d", k), 32'(tick[2]), 32'(((k % 8) == 0) ? 1 : 0));
            check($sformatf("d8_running_%0d", k), 32'(running[2]), 32'h1);
        end

        // Channel 3, D=8: drop enable at cnt=1 (high phase), then re-enable.
        enable = 4'h0;
        step();
        set_div(3, 8);
        enable = 4'b1000;
        step();
        step();
        check("ch3_high_cnt1", 32'(clkout[3]), 32'h1);
        enable = 4'b0000;
        step();
        check("ch3_drop_out", 32'({tick[3], clkout[3], running[3]}), 32'h0);
        enable = 4'b1000;
        step();
        check("ch3_restart_out", 32'({tick[3], clkout[3], running[3]}), 32'h7);
        step();
        check("ch3_second_out", 32'({tick[3], clkout[3], running[3]}), 32'h3);

        // Reset wins over an enabled, running channel.
        reset = 1'b1;
        step();
        check("rst_prio_out", 32'({tick, clkout, running}), 32'h0);
        reset = 1'b0;
        enable = 4'h0;
        step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
